// File: rtl/ps2_codes_pkg.sv
// Shared PS/2 Set-2 constants, decoder state encoding and byte classifiers.
package ps2_codes_pkg;

    localparam logic [7:0]  PS2_EXT        = 8'hE0;
    localparam logic [7:0]  PS2_BRK        = 8'hF0;
    localparam logic [7:0]  PS2_PAUSE      = 8'hE1;
    localparam logic [7:0]  PS2_FAKE_SHIFT = 8'h12;
    localparam int unsigned PAUSE_LEN      = 7;

    localparam int unsigned IGNORED_N = 8;
    localparam logic [7:0] IGNORED_CODES [IGNORED_N] = '{
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF
    };

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        PAUSE
    } ps2_state_t;

    // Controller housekeeping bytes (BAT result, echo, ack, errors, resend).
    function automatic logic is_ignored(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < IGNORED_N; i++) begin
            if (b == IGNORED_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_seq_timer.sv
// Inter-byte watchdog: counts while enabled, pulses expire after TIMEOUT_CYCLES.
module ps2_seq_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int unsigned   CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign expire = enable && !clear && (count == LAST);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || !enable || expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scancode sequence decoder: one make/break event per key action,
// with typematic-repeat suppression, housekeeping-byte filtering and timeout.
module ps2_scancode_decoder
    import ps2_codes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 2_500_000,
    parameter bit          SUPPRESS_REPEAT = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       data_en,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_make,
    output logic       key_valid,
    output logic       seq_error
);
    ps2_state_t state, state_nxt;
    logic [2:0] pause_cnt, pause_cnt_nxt;
    logic [7:0] rec_code, rec_code_nxt;
    logic       rec_ext, rec_ext_nxt, rec_held, rec_held_nxt;

    logic       idle_rules, emit, emit_ext, emit_make, emit_pause, fire, err;
    logic [7:0] emit_code;
    logic       expire;

    logic       evt_pend, err_pend, evt_ext, evt_make;
    logic [7:0] evt_code;

    ps2_seq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .clear   (data_en),
        .enable  (state != IDLE),
        .expire  (expire)
    );

    always_comb begin
        state_nxt     = state;
        pause_cnt_nxt = pause_cnt;
        rec_code_nxt  = rec_code;
        rec_ext_nxt   = rec_ext;
        rec_held_nxt  = rec_held;
        idle_rules    = 1'b0;
        emit          = 1'b0;
        emit_code     = received_data;
        emit_ext      = 1'b0;
        emit_make     = 1'b1;
        emit_pause    = 1'b0;
        err           = 1'b0;

        if (data_en) begin
            if (state == PAUSE) begin
                pause_cnt_nxt = pause_cnt - 3'd1;
                if (pause_cnt == 3'd1) begin
                    emit       = 1'b1;
                    emit_pause = 1'b1;
                    emit_code  = PS2_PAUSE;
                    state_nxt  = IDLE;
                end
            end else if (is_ignored(received_data)) begin
                state_nxt = IDLE;
            end else begin
                case (state)
                    EXT: begin
                        if (received_data == PS2_BRK) begin
                            state_nxt = EXT_BRK;
                        end else if (received_data == PS2_EXT) begin
                            state_nxt = EXT;
                        end else begin
                            state_nxt = IDLE;
                            if (received_data != PS2_FAKE_SHIFT) begin
                                emit     = 1'b1;
                                emit_ext = 1'b1;
                            end
                        end
                    end
                    BRK, EXT_BRK: begin
                        // A prefix inside a break sequence aborts it and starts afresh.
                        if (is_prefix(received_data)) begin
                            err        = 1'b1;
                            idle_rules = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            if (!(state == EXT_BRK && received_data == PS2_FAKE_SHIFT)) begin
                                emit      = 1'b1;
                                emit_ext  = (state == EXT_BRK);
                                emit_make = 1'b0;
                            end
                        end
                    end
                    default: idle_rules = 1'b1;
                endcase

                if (idle_rules) begin
                    case (received_data)
                        PS2_EXT:   state_nxt = EXT;
                        PS2_BRK:   state_nxt = BRK;
                        PS2_PAUSE: begin
                            state_nxt     = PAUSE;
                            pause_cnt_nxt = 3'(PAUSE_LEN);
                        end
                        default: begin
                            state_nxt = IDLE;
                            emit      = 1'b1;
                        end
                    endcase
                end
            end
        end else if (expire) begin
            state_nxt = IDLE;
            err       = 1'b1;
        end

        // Pause has no break code, so it bypasses the held-key record entirely.
        fire = emit;
        if (emit && !emit_pause) begin
            if (emit_make) begin
                if (SUPPRESS_REPEAT && rec_held && rec_code == emit_code && rec_ext == emit_ext) begin
                    fire = 1'b0;
                end else begin
                    rec_code_nxt = emit_code;
                    rec_ext_nxt  = emit_ext;
                    rec_held_nxt = 1'b1;
                end
            end else if (rec_code == emit_code && rec_ext == emit_ext) begin
                rec_held_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pause_cnt    <= '0;
            rec_code     <= '0;
            rec_ext      <= 1'b0;
            rec_held     <= 1'b0;
            evt_pend     <= 1'b0;
            err_pend     <= 1'b0;
            evt_code     <= '0;
            evt_ext      <= 1'b0;
            evt_make     <= 1'b0;
            key_code     <= '0;
            key_extended <= 1'b0;
            key_make     <= 1'b0;
            key_valid    <= 1'b0;
            seq_error    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pause_cnt <= pause_cnt_nxt;
            rec_code  <= rec_code_nxt;
            rec_ext   <= rec_ext_nxt;
            rec_held  <= rec_held_nxt;
            evt_pend  <= fire;
            err_pend  <= err;
            if (fire) begin
                evt_code <= emit_code;
                evt_ext  <= emit_ext;
                evt_make <= emit_make;
            end
            key_valid <= evt_pend;
            seq_error <= err_pend;
            if (evt_pend) begin
                key_code     <= evt_code;
                key_extended <= evt_ext;
                key_make     <= evt_make;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench: two decoders (repeat suppression on/off) fed the same byte stream.
module tb_ps2_scancode_decoder;
    localparam int TO = 100;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] received_data = 8'h00;
    logic       data_en = 1'b0;

    logic [7:0] kc0, kc1;
    logic       ke0, ke1, km0, km1, kv0, kv1, se0, se1;

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1'b1)) u_dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .received_data(received_data), .data_en(data_en),
        .key_code(kc0), .key_extended(ke0), .key_make(km0), .key_valid(kv0), .seq_error(se0));

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1'b0)) u_dut_nr (
        .CLOCK_50(CLOCK_50), .reset(reset), .received_data(received_data), .data_en(data_en),
        .key_code(kc1), .key_extended(ke1), .key_make(km1), .key_valid(kv1), .seq_error(se1));

    always #10 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] code;
        bit         ext;
        bit         make;
        int         at;
    } evt_t;

    evt_t ev_q[2][$];
    int   er_q[2][$];
    int   n_checks = 0;
    int   n_fail = 0;

    logic [7:0] last_c[2];
    bit         last_e[2], last_m[2];

    // Reference model: pending prefix flags plus a per-instance held-key record.
    bit         p_ext, p_brk;
    int         pause_left;
    int         last_acc;
    logic [7:0] rec_code[2];
    bit         rec_ext[2], rec_held[2];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit ign(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    endfunction

    task automatic model_clear();
        p_ext = 0; p_brk = 0; pause_left = 0;
    endtask

    task automatic model_event(input logic [7:0] code, input bit ext, input bit make,
                               input bit pause, input int at);
        evt_t e;
        for (int i = 0; i < 2; i++) begin
            bit drop = 0;
            if (!pause) begin
                if (make) begin
                    if (i == 0 && rec_held[i] && rec_code[i] == code && rec_ext[i] == ext) drop = 1;
                    else begin rec_code[i] = code; rec_ext[i] = ext; rec_held[i] = 1; end
                end else if (rec_code[i] == code && rec_ext[i] == ext) begin
                    rec_held[i] = 0;
                end
            end
            if (!drop) begin
                e.code = code; e.ext = ext; e.make = make; e.at = at;
                ev_q[i].push_back(e);
            end
        end
    endtask

    task automatic model_error(input int at);
        er_q[0].push_back(at);
        er_q[1].push_back(at);
    endtask

    // n = cycle count at the negedge where the byte is driven; accept edge is n+1.
    task automatic model_byte(input logic [7:0] b, input int n);
        last_acc = n + 1;
        if (pause_left > 0) begin
            pause_left--;
            if (pause_left == 0) model_event(8'hE1, 0, 1, 1, n + 2);
            return;
        end
        if (ign(b)) begin model_clear(); return; end
        if (p_brk && b inside {8'hE0, 8'hF0, 8'hE1}) begin
            model_error(n + 2);
            model_clear();
        end
        if (p_brk) begin
            if (!(p_ext && b == 8'h12)) model_event(b, p_ext, 0, 0, n + 2);
            model_clear();
        end else if (p_ext) begin
            if (b == 8'hF0) p_brk = 1;
            else if (b != 8'hE0) begin
                if (b != 8'h12) model_event(b, 1, 1, 0, n + 2);
                model_clear();
            end
        end else begin
            case (b)
                8'hE0:   p_ext = 1;
                8'hF0:   p_brk = 1;
                8'hE1:   pause_left = 7;
                default: model_event(b, 0, 1, 0, n + 2);
            endcase
        end
    endtask

    task automatic model_idle(input int n);
        if ((p_ext || p_brk || pause_left > 0) && (n + 1 - last_acc) == TO) begin
            model_error(n + 2);
            model_clear();
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        received_data = b;
        data_en = 1'b1;
        model_byte(b, cyc);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLOCK_50);
            data_en = 1'b0;
            received_data = 8'h00;
            model_idle(cyc);
        end
    endtask

    task automatic drain_check();
        idle(4);
        for (int i = 0; i < 2; i++) begin
            chk("evt_queue_drained", ev_q[i].size(), 0);
            chk("err_queue_drained", er_q[i].size(), 0);
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        data_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_key_code", {kc0, kc1}, 16'h0000);
        chk("rst_flags", {ke0, km0, kv0, se0, ke1, km1, kv1, se1}, 0);
        repeat (2) @(negedge CLOCK_50);
        model_clear();
        for (int i = 0; i < 2; i++) begin
            rec_code[i] = '0; rec_ext[i] = 0; rec_held[i] = 0;
            last_c[i] = '0; last_e[i] = 0; last_m[i] = 0;
            ev_q[i].delete(); er_q[i].delete();
        end
        reset = 1'b1;
    endtask

    task automatic mon(input int i, input logic [7:0] c, input logic e, input logic m,
                       input logic v, input logic s);
        evt_t x;
        while (ev_q[i].size() > 0 && ev_q[i][0].at < cyc) begin
            chk("evt_missed_at", cyc, ev_q[i][0].at);
            void'(ev_q[i].pop_front());
        end
        while (er_q[i].size() > 0 && er_q[i][0] < cyc) begin
            chk("err_missed_at", cyc, er_q[i][0]);
            void'(er_q[i].pop_front());
        end
        if (v) begin
            chk("evt_expected", int'(ev_q[i].size() > 0), 1);
            if (ev_q[i].size() > 0) begin
                x = ev_q[i].pop_front();
                chk("evt_code", c, x.code);
                chk("evt_ext_make", {e, m}, {x.ext, x.make});
                chk("evt_latency", cyc, x.at);
                last_c[i] = x.code; last_e[i] = x.ext; last_m[i] = x.make;
            end
        end else begin
            chk("evt_hold", {c, e, m}, {last_c[i], last_e[i], last_m[i]});
        end
        if (s) begin
            chk("err_expected", int'(er_q[i].size() > 0), 1);
            if (er_q[i].size() > 0) chk("err_timing", cyc, er_q[i].pop_front());
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (reset) begin
            mon(0, kc0, ke0, km0, kv0, se0);
            mon(1, kc1, ke1, km1, kv1, se1);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    logic [7:0] normal_codes [8] = '{8'h1C, 8'h75, 8'h12, 8'h7C, 8'h14, 8'h77, 8'h5A, 8'h29};
    logic [7:0] ign_codes    [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

    initial begin
        logic [7:0] b;
        int r;
        do_reset();

        send(8'h1C); send(8'hF0); send(8'h1C);
        drain_check();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
        drain_check();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        drain_check();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        drain_check();
        send(8'hE0); idle(TO + 5); send(8'h1C); send(8'hAA); send(8'hFA);
        drain_check();
        send(8'hF0); send(8'hE0); send(8'h75);
        drain_check();
        send(8'hE0); idle(TO - 1); send(8'h75);
        drain_check();
        send(8'hE0);
        do_reset();
        send(8'h75);
        drain_check();

        for (int k = 0; k < 500; k++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      b = normal_codes[$urandom_range(0, 7)];
            else if (r < 67) b = 8'hE0;
            else if (r < 79) b = 8'hF0;
            else if (r < 83) b = 8'hE1;
            else             b = ign_codes[$urandom_range(0, 7)];
            send(b);
            r = $urandom_range(0, 39);
            if (r == 0)      idle(TO);
            else if (r == 1) idle(TO - 1);
            else if (r < 12) idle($urandom_range(1, 5));
        end
        drain_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Consumes the raw byte stream from the PS/2 keyboard receiver (8-bit byte plus one-cycle strobe). Turns Set-2 scancode sequences into one key event per press or release. Each event carries the code, an extended flag and a make/break flag. Sits between the keyboard input stage and the tempo/note control logic. Also suppresses typematic repeats, discards controller housekeeping bytes and recovers from truncated sequences.

Parameters:
TIMEOUT_CYCLES, 2_500_000, CLOCK_50 cycles allowed between bytes of one multi-byte sequence (50 ms) before it is abandoned
SUPPRESS_REPEAT, 1, 1 = drop a repeated make of a key already held; 0 = pass every make through

Ports:
CLOCK_50  input  1  system clock, 50 MHz, all logic on rising edge
reset  input  1  asynchronous, active-low reset
received_data  input  8  byte from PS/2 receiver, valid only when data_en=1
data_en  input  1  one-cycle strobe, byte accepted on the rising edge where it is high
key_code  output  8  scancode of the event (final byte, prefixes stripped)
key_extended  output  1  1 = sequence began with E0
key_make  output  1  1 = press, 0 = release
key_valid  output  1  one-cycle pulse, key_code/key_extended/key_make valid
seq_error  output  1  one-cycle pulse on timeout or malformed prefix

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, timer cleared, held-key record cleared. key_code=8'h00, key_extended=0, key_make=0, key_valid=0, seq_error=0.
- Ignored set I = {00, AA, EE, FA, FC, FD, FE, FF}. In every state except PAUSE these bytes are dropped and the state returns to IDLE without an event. In IDLE they produce no seq_error.
- Latency: key_valid rises on the clock edge after the edge that accepted the final byte of a sequence. It stays high exactly 1 cycle. The event outputs hold their values until the next event.
- State IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE with pause_cnt=7.
  - Any other non-ignored byte -> make event (ext=0), stay IDLE.
- State EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay in EXT.
  - 12 -> drop (fake shift), go to IDLE.
  - Other -> make event (ext=1), go to IDLE.
- State BRK:
  - Non-prefix byte -> break event (ext=0), go to IDLE.
  - E0/F0/E1 -> seq_error pulse, then the byte is reprocessed under the IDLE rules in the same cycle.
- State EXT_BRK:
  - 12 -> drop (fake shift release), go to IDLE.
  - E0/F0/E1 -> seq_error pulse plus IDLE reprocessing, as in BRK.
  - Other -> break event (ext=1), go to IDLE.
- State PAUSE:
  - Every byte, ignored set included, decrements pause_cnt.
  - On the byte where the count reaches 0: make event key_code=E1, ext=0, go to IDLE.
  - Pause never produces a break event.
- Timeout:
  - The timer clears on every accepted byte and counts while state != IDLE.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse seq_error, no event.
  - If data_en arrives in the same cycle as expiry, the byte wins: it is processed and the timer clears.
- Repeat suppression (SUPPRESS_REPEAT=1):
  - Record {last_code, last_ext, held}.
  - Make matching the record with held=1 -> no event.
  - Any other make -> emit the event, load the record, set held=1.
  - Break matching the record -> held=0.
  - Break events are always emitted.
- A new data_en may arrive on consecutive cycles. The block accepts one byte per cycle and never stalls; there is no backpressure.
- Reset asserted mid-sequence: the partial sequence is discarded and no event or error is produced.

Decomposition:
- Shared package ps2_codes_pkg:
  - Constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_FAKE_SHIFT=8'h12, PAUSE_LEN=7.
  - Ignored-set list.
  - State encoding typedef {IDLE, EXT, BRK, EXT_BRK, PAUSE}.
- One sub-module: ps2_seq_timer. Parameter TIMEOUT_CYCLES; inputs clear and enable; output expire pulse; counter width $clog2(TIMEOUT_CYCLES).

Test Plan:
- Bytes 1C, F0, 1C -> events {1C, ext0, make1} then {1C, ext0, make0}. Each key_valid lasts 1 cycle and follows the final byte by 1 cycle.
- Bytes E0, 75, E0, F0, 75 -> {75, ext1, make1} then {75, ext1, make0}. E0 12 E0 7C (PrtScn make) -> only {7C, ext1, make1}; the fake shift 12 is dropped.
- Bytes 1C, 1C, 1C, F0, 1C with SUPPRESS_REPEAT=1 -> exactly one make and one break. With SUPPRESS_REPEAT=0 -> three makes and one break.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> one event {E1, ext0, make1}, no other events, no seq_error.
- E0 then silence for TIMEOUT_CYCLES (use 100 in sim) -> seq_error pulse, no key_valid. A following 1C -> {1C, ext0, make1}. Also drive AA and FA in IDLE -> no events, no seq_error.
- Assert reset between E0 and 75 -> all outputs 0. After release, 75 alone -> {75, ext0, make1}.
